wb_trace_display: RTL and testbench

//  Downstream consumer of the pipeline's MEM/WB stage. Captures every register

---
 rtl/wb_trace_display_pkg.sv | 24 ++
 rtl/wb_trace_display_if.sv | 9 +
 rtl/wb_trace_display_fifo.sv | 72 +++++++
 rtl/wb_trace_display.sv | 126 ++++++++++++
 tb/tb_wb_trace_display.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_trace_display_pkg.sv
// Shared types and constants for the MEM/WB writeback trace display.
package proc_pkg;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_entry_t;

  typedef enum logic {
    ST_EMPTY,
    ST_SHOW
  } disp_state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_FONT [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [6:0] SEG_DASH = 7'b0111111;

endpackage

// File: rtl/wb_trace_display_if.sv
// Writeback bus from the MEM/WB pipeline stage.
interface wb_trace_display_if;
  logic        WbValid;
  logic [4:0]  WbAddr;
  logic [31:0] WbData;

  modport master (output WbValid, output WbAddr, output WbData);
  modport slave  (input  WbValid, input  WbAddr, input  WbData);
endinterface

// File: rtl/wb_trace_display_fifo.sv
// Synchronous FIFO of writeback entries; head is read combinationally.
module wb_trace_fifo
  import proc_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_entry_t              din,
  output logic                   push_ok,
  input  logic                   pop,
  output wb_entry_t              dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic          pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/wb_trace_display.sv
// Captures register writebacks into a FIFO and shows them one at a time on
// an 8-digit multiplexed 7-segment display.
module wb_trace_display
  import proc_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned HOLD_CYCLES = 2**24,
  parameter int unsigned SCAN_BITS   = 16
) (
  input  logic                   clk,
  input  logic                   Reset,
  wb_trace_display_if.slave      wb,
  input  logic                   Step,
  input  logic                   AutoAdv,
  output logic [6:0]             Seg,
  output logic [7:0]             An,
  output logic [4:0]             ShownAddr,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Overflow
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned HW = $clog2(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  disp_state_t          state_q, state_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [SCAN_BITS-1:0] cnt_q, cnt_d;
  logic [6:0]           seg_q, seg_d;
  logic [7:0]           an_q, an_d;
  logic                 overflow_q, overflow_d;

  wb_entry_t            head;
  wb_entry_t            wb_in;
  logic                 push_acc;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        fifo_count;
  logic [2:0]           idx;
  logic [3:0]           nib;

  assign wb_in.addr = wb.WbAddr;
  assign wb_in.data = wb.WbData;

  wb_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (Reset),
    .push    (wb.WbValid),
    .din     (wb_in),
    .push_ok (push_acc),
    .pop     (pop),
    .dout    (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  // Advance event: a Step and an expiry in the same cycle still pop once.
  // Kept apart from the next-state logic so push acceptance, which depends
  // on pop, does not form an apparent combinational loop.
  always_comb begin
    pop = 1'b0;
    if (state_q == ST_SHOW) begin
      pop = Step || (AutoAdv && (hold_q == HOLD_LAST));
    end
  end

  // Display FSM next state, hold counter and sticky overflow.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    overflow_d = overflow_q | (wb.WbValid & ~push_acc);
    case (state_q)
      ST_EMPTY: begin
        hold_d = '0;
        if (fifo_count != '0) state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (pop) begin
          hold_d = '0;
          // A push landing on the last pop becomes the new head.
          if (!((fifo_count > CW'(1)) || push_acc)) state_d = ST_EMPTY;
        end else begin
          hold_d = (hold_q == HOLD_LAST) ? '0 : hold_q + 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Digit scan and font lookup; Seg and An register together.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx   = cnt_q[SCAN_BITS-1 -: 3];
    nib   = head.data[{idx, 2'b00} +: 4];
    an_d  = ~(8'b1 << idx);
    seg_d = (state_q == ST_SHOW) ? SEG_FONT[nib] : SEG_DASH;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= ST_EMPTY;
      hold_q     <= '0;
      cnt_q      <= '0;
      seg_q      <= SEG_DASH;
      an_q       <= 8'b1111_1110;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      cnt_q      <= cnt_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      overflow_q <= overflow_d;
    end
  end

  assign Seg       = seg_q;
  assign An        = an_q;
  assign Count     = fifo_count;
  assign Overflow  = overflow_q;
  assign ShownAddr = (state_q == ST_SHOW) ? head.addr : 5'd0;

endmodule

// File: tb/tb_wb_trace_display.sv
// Directed bench for wb_trace_display (DEPTH=4, HOLD_CYCLES=10, SCAN_BITS=4).
module tb_wb_trace_display;

  localparam logic [6:0] S_DASH = 7'b0111111;
  localparam logic [6:0] S_1    = 7'b1111001;
  localparam logic [6:0] S_2    = 7'b0100100;
  localparam logic [6:0] S_C    = 7'b1000110;
  localparam logic [6:0] S_D    = 7'b0100001;

  logic       clk = 1'b0;
  logic       Reset;
  logic       Step;
  logic       AutoAdv;
  logic [6:0] Seg;
  logic [7:0] An;
  logic [4:0] ShownAddr;
  logic [2:0] Count;
  logic       Overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  wb_trace_display_if wb_if ();

  wb_trace_display #(
    .DEPTH       (4),
    .HOLD_CYCLES (10),
    .SCAN_BITS   (4)
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .wb        (wb_if),
    .Step      (Step),
    .AutoAdv   (AutoAdv),
    .Seg       (Seg),
    .An        (An),
    .ShownAddr (ShownAddr),
    .Count     (Count),
    .Overflow  (Overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance at least one cycle, then until digit k is enabled (bounded).
  task automatic wait_digit(input int unsigned k);
    logic [7:0] target;
    int n;
    target = ~(8'b1 << k);
    n = 0;
    tick();
    while (An !== target && n < 40) begin
      tick();
      n++;
    end
    check("scan_reaches_digit", {24'd0, An}, {24'd0, target});
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wb_if.WbValid = 1'b1;
    wb_if.WbAddr  = a;
    wb_if.WbData  = d;
    tick();
    wb_if.WbValid = 1'b0;
  endtask

  task automatic step_pulse();
    Step = 1'b1;
    tick();
    Step = 1'b0;
  endtask

  initial begin
    Reset         = 1'b1;
    Step          = 1'b0;
    AutoAdv       = 1'b0;
    wb_if.WbValid = 1'b0;
    wb_if.WbAddr  = '0;
    wb_if.WbData  = '0;

    // 1: reset state and dashes across a full scan
    repeat (3) tick();
    check("rst_count", {29'd0, Count}, 32'd0);
    check("rst_overflow", {31'd0, Overflow}, 32'd0);
    check("rst_shownaddr", {27'd0, ShownAddr}, 32'd0);
    check("rst_an", {24'd0, An}, 32'h0000_00FE);
    check("rst_seg", {25'd0, Seg}, {25'd0, S_DASH});
    Reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("empty_seg_dash", {25'd0, Seg}, {25'd0, S_DASH});
      check("an_one_hot_low", $countones(An), 32'd7);
    end
    wait_digit(7);
    check("empty_digit7_dash", {25'd0, Seg}, {25'd0, S_DASH});

    // 2: single entry, held until Step
    push(5'd5, 32'h1234_ABCD);
    check("single_count", {29'd0, Count}, 32'd1);
    tick();
    check("single_addr", {27'd0, ShownAddr}, 32'd5);
    wait_digit(0);
    check("single_digit0_D", {25'd0, Seg}, {25'd0, S_D});
    wait_digit(1);
    check("single_digit1_C", {25'd0, Seg}, {25'd0, S_C});
    wait_digit(7);
    check("single_digit7_1", {25'd0, Seg}, {25'd0, S_1});
    repeat (30) tick();
    check("single_held_addr", {27'd0, ShownAddr}, 32'd5);
    check("single_held_count", {29'd0, Count}, 32'd1);
    step_pulse();
    check("single_popped_count", {29'd0, Count}, 32'd0);
    check("single_popped_addr", {27'd0, ShownAddr}, 32'd0);
    wait_digit(3);
    check("single_popped_dash", {25'd0, Seg}, {25'd0, S_DASH});

    // 3: six pushes into a 4-deep FIFO
    for (int i = 1; i <= 6; i++) push(5'(i), 32'hA000_0000 | i);
    check("ovf_count", {29'd0, Count}, 32'd4);
    check("ovf_flag", {31'd0, Overflow}, 32'd1);
    check("ovf_head1", {27'd0, ShownAddr}, 32'd1);
    wait_digit(0);
    check("ovf_head1_digit0", {25'd0, Seg}, {25'd0, S_1});
    step_pulse();
    check("ovf_head2", {27'd0, ShownAddr}, 32'd2);
    wait_digit(0);
    check("ovf_head2_digit0", {25'd0, Seg}, {25'd0, S_2});
    step_pulse();
    check("ovf_head3", {27'd0, ShownAddr}, 32'd3);
    step_pulse();
    check("ovf_head4", {27'd0, ShownAddr}, 32'd4);
    step_pulse();
    check("ovf_drained_addr", {27'd0, ShownAddr}, 32'd0);
    check("ovf_drained_count", {29'd0, Count}, 32'd0);
    check("ovf_sticky", {31'd0, Overflow}, 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("ovf_cleared", {31'd0, Overflow}, 32'd0);

    // 4: auto-advance, 10 cycles per entry; Step on expiry pops once
    AutoAdv = 1'b1;
    push(5'd7, 32'h0000_0007);
    check("auto_still_empty", {27'd0, ShownAddr}, 32'd0);
    push(5'd8, 32'h0000_0008);
    for (int i = 0; i < 10; i++) begin
      check("auto_first_shown", {27'd0, ShownAddr}, 32'd7);
      if (i == 9) Step = 1'b1;
      tick();
      Step = 1'b0;
    end
    check("auto_single_pop_count", {29'd0, Count}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("auto_second_shown", {27'd0, ShownAddr}, 32'd8);
      tick();
    end
    check("auto_end_addr", {27'd0, ShownAddr}, 32'd0);
    check("auto_end_count", {29'd0, Count}, 32'd0);
    AutoAdv = 1'b0;

    // 5: push and pop together while full
    for (int i = 10; i <= 13; i++) begin
      wb_if.WbValid = 1'b1;
      wb_if.WbAddr  = 5'(i);
      wb_if.WbData  = 32'(i);
      tick();
    end
    check("full_count", {29'd0, Count}, 32'd4);
    check("full_head", {27'd0, ShownAddr}, 32'd10);
    wb_if.WbAddr = 5'd14;
    wb_if.WbData = 32'd14;
    Step         = 1'b1;
    tick();
    wb_if.WbValid = 1'b0;
    Step          = 1'b0;
    check("full_pushpop_count", {29'd0, Count}, 32'd4);
    check("full_pushpop_ovf", {31'd0, Overflow}, 32'd0);
    check("full_pushpop_head", {27'd0, ShownAddr}, 32'd11);
    for (int i = 12; i <= 14; i++) begin
      step_pulse();
      check("full_drain_head", {27'd0, ShownAddr}, 32'(i));
    end
    step_pulse();
    check("full_drain_empty", {29'd0, Count}, 32'd0);

    // 6: reset during SHOW with three entries
    push(5'd20, 32'h2020_2020);
    push(5'd21, 32'h2121_2121);
    push(5'd22, 32'h2222_2222);
    tick();
    check("mid_count", {29'd0, Count}, 32'd3);
    check("mid_head", {27'd0, ShownAddr}, 32'd20);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("mid_rst_count", {29'd0, Count}, 32'd0);
    check("mid_rst_addr", {27'd0, ShownAddr}, 32'd0);
    check("mid_rst_seg", {25'd0, Seg}, {25'd0, S_DASH});
    check("mid_rst_an", {24'd0, An}, 32'h0000_00FE);
    wait_digit(5);
    check("mid_rst_digit5_dash", {25'd0, Seg}, {25'd0, S_DASH});
    check("mid_rst_stays_empty", {29'd0, Count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
